// File: rtl/mem_stage_pkg.sv
// Shared types and defaults for the memory-stage unit: op codes, FSM states,
// default widths and small op-classification helpers.
package mem_stage_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 16;
  localparam int FLAG_W_DEF = 3;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_LDM   = 3'd1,
    OP_LDD   = 3'd2,
    OP_STD   = 3'd3,
    OP_PUSH  = 3'd4,
    OP_POP   = 3'd5,
    OP_PUSH2 = 3'd6,
    OP_POP2  = 3'd7
  } op_code_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  function automatic logic is_two_word(input op_code_t op);
    return (op == OP_PUSH2) || (op == OP_POP2);
  endfunction

  function automatic logic is_mem_op(input op_code_t op);
    return (op != OP_NOP) && (op != OP_LDM);
  endfunction

  function automatic logic is_stack_op(input op_code_t op);
    return (op == OP_PUSH) || (op == OP_POP) || (op == OP_PUSH2) || (op == OP_POP2);
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge bus; the unit is master, the memory slave.
interface mem_stage_if import mem_stage_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );

endinterface

// File: rtl/mem_sp_reg.sv
// Stack pointer register: steps by 1 or 2 in either direction, wraps modulo
// 2**ADDR_W, and flags the empty / about-to-wrap conditions.
module mem_sp_reg import mem_stage_pkg::*; #(
  parameter int                ADDR_W  = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] SP_INIT = '1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              step,
  input  logic              up,
  input  logic              two,
  output logic [ADDR_W-1:0] sp,
  output logic              empty,
  output logic              wrap1,
  output logic              wrap2
);

  logic [ADDR_W-1:0] delta;

  assign delta = two ? ADDR_W'(2) : ADDR_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp <= SP_INIT;
    end else if (step) begin
      sp <= up ? sp + delta : sp - delta;
    end
  end

  // A single push wraps only from 0; a double push also wraps from 1.
  assign empty = (sp == SP_INIT);
  assign wrap1 = (sp == '0);
  assign wrap2 = (sp[ADDR_W-1:1] == '0);

endmodule

// File: rtl/mem_stage_unit.sv
// Memory-stage execution unit: LDM/LDD/STD and single/double stack transfers
// over a req/ack data-memory bus, stalling on wait states.
//   state     | meaning
//   ST_IDLE   | ready for a new op (op_ready high)
//   ST_ACCESS | memory request outstanding, word 0 or word 1 of a pair
//   ST_DONE   | result / stack_err presented for one cycle
module mem_stage_unit import mem_stage_pkg::*; #(
  parameter int                DATA_W  = DATA_W_DEF,
  parameter int                ADDR_W  = ADDR_W_DEF,
  parameter int                FLAG_W  = FLAG_W_DEF,
  parameter logic [ADDR_W-1:0] SP_INIT = '1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                op_valid,
  output logic                op_ready,
  input  logic [2:0]          op_code,
  input  logic [DATA_W-1:0]   op_imm,
  input  logic [ADDR_W-1:0]   op_addr,
  input  logic [2*DATA_W-1:0] op_wdata,
  input  logic [FLAG_W-1:0]   flags_in,
  mem_stage_if.master         bus,
  output logic                res_valid,
  output logic [2*DATA_W-1:0] res_data,
  output logic [FLAG_W-1:0]   res_flags,
  output logic                stack_err,
  output logic [ADDR_W-1:0]   sp
);

  state_t            state, state_nxt;
  op_code_t          op_in, op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [2*DATA_W-1:0] wdata_q;
  logic              word_q;
  logic              err_q, err_d;
  logic              accept, last_word, word_ack;
  logic              sp_empty, sp_wrap1, sp_wrap2;

  assign op_in = op_code_t'(op_code);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    op_ready      = 1'b0;
    accept        = 1'b0;
    res_valid     = 1'b0;
    stack_err     = 1'b0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    last_word     = !is_two_word(op_q) || word_q;
    word_ack      = 1'b0;
    err_d         = 1'b0;

    case (op_in)
      OP_POP, OP_POP2: err_d = sp_empty;
      OP_PUSH:         err_d = sp_wrap1;
      OP_PUSH2:        err_d = sp_wrap2;
      default:         err_d = 1'b0;
    endcase

    case (state)
      ST_IDLE: begin
        op_ready = 1'b1;
        accept   = op_valid;
        if (op_valid) begin
          state_nxt = is_mem_op(op_in) ? ST_ACCESS : ST_DONE;
        end
      end
      ST_ACCESS: begin
        bus.mem_req = 1'b1;
        bus.mem_we  = (op_q == OP_STD) || (op_q == OP_PUSH) || (op_q == OP_PUSH2);
        word_ack    = bus.mem_ack;
        // sp only moves after the last ack, so all stack addresses derive from it
        case (op_q)
          OP_LDD, OP_STD: bus.mem_addr = addr_q;
          OP_PUSH:        bus.mem_addr = sp;
          OP_POP:         bus.mem_addr = sp + ADDR_W'(1);
          OP_PUSH2:       bus.mem_addr = word_q ? sp - ADDR_W'(1) : sp;
          OP_POP2:        bus.mem_addr = word_q ? sp + ADDR_W'(2) : sp + ADDR_W'(1);
          default:        bus.mem_addr = '0;
        endcase
        bus.mem_wdata = (op_q == OP_PUSH2 && !word_q) ? wdata_q[2*DATA_W-1:DATA_W]
                                                     : wdata_q[DATA_W-1:0];
        if (bus.mem_ack && last_word) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        res_valid = 1'b1;
        stack_err = err_q;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= OP_NOP;
      addr_q    <= '0;
      wdata_q   <= '0;
      word_q    <= 1'b0;
      err_q     <= 1'b0;
      res_data  <= '0;
      res_flags <= '0;
    end else if (accept) begin
      op_q      <= op_in;
      addr_q    <= op_addr;
      wdata_q   <= op_wdata;
      word_q    <= 1'b0;
      err_q     <= err_d;
      res_flags <= flags_in;
      res_data  <= (op_in == OP_LDM) ? {{DATA_W{1'b0}}, op_imm} : '0;
    end else if (word_ack) begin
      word_q <= 1'b1;
      case (op_q)
        OP_LDD, OP_POP: res_data[DATA_W-1:0] <= bus.mem_rdata;
        OP_POP2: begin
          if (word_q) res_data[2*DATA_W-1:DATA_W] <= bus.mem_rdata;
          else        res_data[DATA_W-1:0]        <= bus.mem_rdata;
        end
        default: ;
      endcase
    end
  end

  mem_sp_reg #(
    .ADDR_W  (ADDR_W),
    .SP_INIT (SP_INIT)
  ) u_sp (
    .clk   (clk),
    .rst_n (rst_n),
    .step  (word_ack && last_word && is_stack_op(op_q)),
    .up    ((op_q == OP_POP) || (op_q == OP_POP2)),
    .two   (is_two_word(op_q)),
    .sp    (sp),
    .empty (sp_empty),
    .wrap1 (sp_wrap1),
    .wrap2 (sp_wrap2)
  );

endmodule

// File: doc/mem_stage_unit.md
# mem_stage_unit

Parametrised memory-stage execution unit for the RISC pipeline, replacing the per-instruction combinational pass-through blocks (LDM, LDD, STD, PUSH). It owns the stack pointer and drives the data-memory request/acknowledge handshake, so memory wait states stall the stage. It supports single- and double-word stack transfers, for example PC save/restore on CALL/RET. Results go to write-back with the condition-code flags passed through unchanged.

## Interface
- DATA_W, 16, data word width
- ADDR_W, 16, word-address width
- FLAG_W, 3, CCR width
- SP_INIT, 2**ADDR_W-1, stack pointer reset value (stack grows down)
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- op_valid  in  1  operation offered
- op_ready  out  1  unit can accept (high only in IDLE)
- op_code  in  3  0 NOP, 1 LDM, 2 LDD, 3 STD, 4 PUSH, 5 POP, 6 PUSH2, 7 POP2
- op_imm  in  DATA_W  LDM immediate
- op_addr  in  ADDR_W  effective address for LDD/STD
- op_wdata  in  2*DATA_W  store data (low word for single-word ops)
- flags_in  in  FLAG_W  CCR at issue
- mem_req / mem_we  out  1 / 1  request, write enable
- mem_addr  out  ADDR_W; mem_wdata out DATA_W
- mem_ack  in  1; mem_rdata in DATA_W  (read data valid with ack)
- res_valid  out  1  one-cycle result pulse
- res_data  out  2*DATA_W  result (upper word zero for single-word ops)
- res_flags  out  FLAG_W  flags_in captured at accept
- stack_err  out  1  pulses with res_valid on over/underflow
- sp  out  ADDR_W  current stack pointer

## Operation
- FSM: IDLE -> ACCESS (1 or 2 words) -> DONE -> IDLE. LDM and NOP go IDLE -> DONE.
- Accept on op_valid && op_ready. Latch op_code, op_imm, op_addr, op_wdata and flags_in.
- LDM: res_data = op_imm. NOP: res_valid pulses, res_data = 0.
- LDD: read op_addr. STD: write op_wdata[DATA_W-1:0] to op_addr.
- PUSH: write the low word at sp, then sp -= 1 on ack (post-decrement).
- POP: read sp+1; on ack sp += 1.
- PUSH2: write the high word at sp, then the low word at sp-1. sp -= 2 after the second ack.
- POP2: read the low word at sp+1, then the high word at sp+2. sp += 2 after the second ack.
- Address arithmetic is modulo 2**ADDR_W; sp wraps.
- stack_err is set when a POP/POP2 starts with sp == SP_INIT (empty), or a PUSH/PUSH2 would wrap past 0. The operation still completes.
- Memory ops never modify flags: res_flags = captured flags_in.
- Write ops (STD/PUSH/PUSH2) pulse res_valid with res_data = 0.

## Timing
- Reset (asynchronous, rst_n low):
  - state IDLE, sp = SP_INIT.
  - mem_req, mem_we, res_valid, stack_err = 0.
  - mem_addr, mem_wdata, res_data, res_flags = 0.
  - op_ready = 1 after release.
- Reset mid-access drops mem_req immediately, abandons the transaction and leaves sp at SP_INIT.
- mem_req rises the cycle after accept. mem_req, mem_we, mem_addr and mem_wdata are held stable until mem_ack is sampled high.
- Back-to-back words: the second request starts the cycle after the first ack (mem_req stays high, address updates).
- Zero-wait memory: ack in the same cycle as req is legal.
- Single-access latency is accept edge N, req in cycle N+1, res_valid in cycle N+2 at minimum.
- LDM latency: res_valid in cycle N+1.
- op_ready is low from accept through DONE, so the minimum issue interval is 3 cycles for memory ops and 2 for LDM.
- mem_ack outside ACCESS is ignored.

## Structure
- Package mem_stage_pkg: op_code enum, FSM state enum, default parameter constants.
- Sub-module mem_sp_reg holds the stack pointer. It has asynchronous reset to SP_INIT, inc/dec by 1 or 2, and empty/wrap detection driving stack_err.

## Test plan
- LDM: op_imm=0x1234, flags_in=3'b101 -> res_valid in cycle N+1, res_data=0x1234, res_flags=3'b101, no mem_req.
- Stall: STD addr=0x0040, data=0xBEEF, ack delayed 3 cycles -> mem_req/addr/wdata stable for 4 cycles, res_valid 1 cycle after ack, op_ready low throughout.
- PUSH2 then POP2 with zero-wait memory:
  - PUSH2 writes 0xAAAA to 0xFFFF and 0x5555 to 0xFFFE, leaving sp=0xFFFD.
  - POP2 returns res_data=0xAAAA5555 with sp=0xFFFF.
- POP on an empty stack (sp=0xFFFF) -> reads 0x0000, sp wraps to 0x0000, stack_err pulses with res_valid.
- rst_n asserted between the two PUSH2 acks -> mem_req low immediately, sp=0xFFFF, op_ready=1 after release, no res_valid.
- Stray mem_ack in IDLE plus op_valid held during DONE -> no state change, second op accepted only when op_ready returns.
